sme_job_sequencer: RTL

//  Batch controller in front of the SME string-match engine. The host loads one

---
 rtl/sme_job_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sme_job_sequencer.sv
// Batch controller in front of the SME string-match engine: buffers one string and up to
// NUM_PAT patterns, replays them serially to the engine and returns one tagged result per pattern.
module sme_job_sequencer #(
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int NUM_PAT = 4,
    parameter int TIMEOUT = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_wr,
    input  logic                       host_sel,
    input  logic                       host_eop,
    input  logic [7:0]                 host_data,
    input  logic                       host_go,
    output logic                       host_ready,
    output logic                       load_ovf,
    output logic [7:0]                 sme_chardata,
    output logic                       sme_isstring,
    output logic                       sme_ispattern,
    input  logic                       sme_valid,
    input  logic                       sme_match,
    input  logic [4:0]                 sme_index,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_PAT)-1:0] res_id,
    output logic                       res_match,
    output logic [4:0]                 res_index,
    output logic                       res_timeout,
    output logic                       job_done
);

    localparam int SW  = $clog2(MAX_STR + 1);
    localparam int SAW = $clog2(MAX_STR);
    localparam int PW  = $clog2(MAX_PAT + 1);
    localparam int PAW = $clog2(MAX_PAT);
    localparam int CW  = $clog2(NUM_PAT + 1);
    localparam int IW  = $clog2(NUM_PAT);
    localparam int TW  = $clog2(TIMEOUT);

    localparam logic [SW-1:0] STR_MAX_C = SW'(MAX_STR);
    localparam logic [SW-1:0] SONE_C    = SW'(1);
    localparam logic [PW-1:0] PAT_MAX_C = PW'(MAX_PAT);
    localparam logic [PW-1:0] PONE_C    = PW'(1);
    localparam logic [CW-1:0] CNT_MAX_C = CW'(NUM_PAT);
    localparam logic [CW-1:0] CONE_C    = CW'(1);
    localparam logic [IW-1:0] IONE_C    = IW'(1);
    localparam logic [TW-1:0] TONE_C    = TW'(1);
    localparam logic [TW-1:0] TMR_MAX_C = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_STR = 3'd1,
        S_SEND_PAT = 3'd2,
        S_WAIT     = 3'd3,
        S_REPORT   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [7:0]    str_buf_r [MAX_STR];
    logic [SW-1:0] str_len_r;
    logic          str_new_r, str_dirty_r;
    logic [7:0]    pat_buf_r [NUM_PAT][MAX_PAT];
    logic [PW-1:0] pat_len_r [NUM_PAT];
    logic [CW-1:0] pat_cnt_r;
    logic          load_ovf_r;
    logic [SW-1:0] idx_r;
    logic [IW-1:0] cur_r;
    logic [TW-1:0] timer_r;
    logic          res_match_r, res_timeout_r;
    logic [4:0]    res_index_r;

    logic          idle_s, str_wr_s, pat_wr_s, go_s, str_full_s, slot_full_s;
    logic [PW-1:0] slot_len_s;
    logic          pat_take_s, pat_close_s, ovf_set_s, dirty_ld_s, str_some_s;
    logic [CW-1:0] pat_cnt_ld_s;
    logic          str_last_s, pat_last_s, last_res_s;

    // Host load decode; the *_ld_s terms let a char written alongside go count for that go
    always_comb begin
        idle_s       = (state_r == S_IDLE);
        str_wr_s     = idle_s & host_wr & ~host_sel;
        pat_wr_s     = idle_s & host_wr & host_sel;
        go_s         = idle_s & host_go;
        str_full_s   = ~str_new_r & (str_len_r == STR_MAX_C);
        slot_full_s  = (pat_cnt_r == CNT_MAX_C);
        slot_len_s   = pat_len_r[pat_cnt_r[IW-1:0]];
        pat_take_s   = pat_wr_s & ~slot_full_s & (slot_len_s != PAT_MAX_C);
        pat_close_s  = pat_wr_s & ~slot_full_s & host_eop & (pat_take_s | (slot_len_s != {PW{1'b0}}));
        ovf_set_s    = (str_wr_s & str_full_s) | (pat_wr_s & ~pat_take_s);
        pat_cnt_ld_s = pat_close_s ? (pat_cnt_r + CONE_C) : pat_cnt_r;
        dirty_ld_s   = str_dirty_r | (str_wr_s & str_new_r);
        str_some_s   = (str_len_r != {SW{1'b0}}) | str_wr_s;
        str_last_s   = ((idx_r + SONE_C) == str_len_r);
        pat_last_s   = ((idx_r + SONE_C) == SW'(pat_len_r[cur_r]));
        last_res_s   = ((CW'(cur_r) + CONE_C) == pat_cnt_r);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!go_s) begin
                    state_s = S_IDLE;
                end else if (pat_cnt_ld_s == {CW{1'b0}}) begin
                    state_s = S_DONE;
                end else if (dirty_ld_s && str_some_s) begin
                    state_s = S_SEND_STR;
                end else begin
                    state_s = S_SEND_PAT;
                end
            end
            S_SEND_STR: state_s = str_last_s ? S_SEND_PAT : S_SEND_STR;
            S_SEND_PAT: state_s = pat_last_s ? S_WAIT : S_SEND_PAT;
            S_WAIT:     state_s = (sme_valid || (timer_r == TMR_MAX_C)) ? S_REPORT : S_WAIT;
            S_REPORT: begin
                if (!res_ready) begin
                    state_s = S_REPORT;
                end else if (last_res_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_SEND_PAT;
                end
            end
            S_DONE:     state_s = S_IDLE;
            default:    state_s = S_IDLE;
        endcase
    end

    // Output decode from registered state and buffers
    always_comb begin
        host_ready    = 1'b0;
        sme_chardata  = 8'h00;
        sme_isstring  = 1'b0;
        sme_ispattern = 1'b0;
        res_valid     = 1'b0;
        job_done      = 1'b0;
        case (state_r)
            S_IDLE:     host_ready = 1'b1;
            S_SEND_STR: begin
                sme_isstring = 1'b1;
                sme_chardata = str_buf_r[idx_r[SAW-1:0]];
            end
            S_SEND_PAT: begin
                sme_ispattern = 1'b1;
                sme_chardata  = pat_buf_r[cur_r][idx_r[PAW-1:0]];
            end
            S_REPORT:   res_valid = 1'b1;
            S_DONE:     job_done = 1'b1;
            default:    host_ready = 1'b0;
        endcase
    end

    assign load_ovf    = load_ovf_r;
    assign res_id      = cur_r;
    assign res_match   = res_match_r;
    assign res_index   = res_index_r;
    assign res_timeout = res_timeout_r;

    // Buffer loading, per-state counters and result latching
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_STR; i++) str_buf_r[i] <= 8'h00;
            for (int p = 0; p < NUM_PAT; p++) begin
                pat_len_r[p] <= {PW{1'b0}};
                for (int c = 0; c < MAX_PAT; c++) pat_buf_r[p][c] <= 8'h00;
            end
            str_len_r     <= {SW{1'b0}};
            str_new_r     <= 1'b1;
            str_dirty_r   <= 1'b0;
            pat_cnt_r     <= {CW{1'b0}};
            load_ovf_r    <= 1'b0;
            idx_r         <= {SW{1'b0}};
            cur_r         <= {IW{1'b0}};
            timer_r       <= {TW{1'b0}};
            res_match_r   <= 1'b0;
            res_index_r   <= 5'd0;
            res_timeout_r <= 1'b0;
        end else begin
            if (str_wr_s) begin
                if (str_new_r) begin
                    str_buf_r[0] <= host_data;
                    str_len_r    <= SONE_C;
                    str_new_r    <= 1'b0;
                    str_dirty_r  <= 1'b1;
                end else if (!str_full_s) begin
                    str_buf_r[str_len_r[SAW-1:0]] <= host_data;
                    str_len_r <= str_len_r + SONE_C;
                end
            end
            if (pat_take_s) begin
                pat_buf_r[pat_cnt_r[IW-1:0]][slot_len_s[PAW-1:0]] <= host_data;
                pat_len_r[pat_cnt_r[IW-1:0]] <= slot_len_s + PONE_C;
            end
            if (pat_close_s) begin
                pat_cnt_r <= pat_cnt_r + CONE_C;
            end
            // go acts after any char taken in the same cycle
            if (go_s) begin
                load_ovf_r <= 1'b0;
                str_new_r  <= 1'b1;
                if (pat_cnt_ld_s != {CW{1'b0}}) begin
                    str_dirty_r <= 1'b0;
                end
            end else if (ovf_set_s) begin
                load_ovf_r <= 1'b1;
            end

            case (state_r)
                S_IDLE: begin
                    idx_r   <= {SW{1'b0}};
                    cur_r   <= {IW{1'b0}};
                    timer_r <= {TW{1'b0}};
                end
                S_SEND_STR: idx_r <= str_last_s ? {SW{1'b0}} : (idx_r + SONE_C);
                S_SEND_PAT: begin
                    idx_r   <= pat_last_s ? {SW{1'b0}} : (idx_r + SONE_C);
                    timer_r <= {TW{1'b0}};
                end
                S_WAIT: begin
                    timer_r <= timer_r + TONE_C;
                    if (sme_valid) begin
                        res_match_r   <= sme_match;
                        res_index_r   <= sme_match ? sme_index : 5'd0;
                        res_timeout_r <= 1'b0;
                    end else if (timer_r == TMR_MAX_C) begin
                        // engine state is unknown after a timeout: reload the string next job
                        res_match_r   <= 1'b0;
                        res_index_r   <= 5'd0;
                        res_timeout_r <= 1'b1;
                        str_dirty_r   <= 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready && !last_res_s) begin
                        cur_r <= cur_r + IONE_C;
                    end
                end
                S_DONE: begin
                    pat_cnt_r <= {CW{1'b0}};
                    for (int p = 0; p < NUM_PAT; p++) pat_len_r[p] <= {PW{1'b0}};
                end
                default: idx_r <= {SW{1'b0}};
            endcase
        end
    end

endmodule
